// File: rtl/perfect_scan_ctrl.sv
// Sweeps lo..hi through one isPerfect checker and records the perfect numbers found.
// Optional per-candidate watchdog is enabled by defining PSCAN_TIMEOUT_EN.
module perfect_scan_ctrl #(
    parameter int MAX_FOUND      = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      lo,
    input  logic [15:0]      hi,
    output logic             busy,
    output logic             done,
    output logic [15:0]      cur_num,
    output logic [7:0]       found_cnt,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [15:0]      rd_data,
    output logic             chk_rst,
    output logic             chk_go,
    output logic [15:0]      chk_num,
    input  logic             chk_ans,
    input  logic             chk_over,
    output logic             err
);

    localparam int CNT_W = $clog2(MAX_FOUND + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_GO,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      cur_num_q, cur_num_d;
    logic [15:0]      hi_q, hi_d;
    logic [7:0]       found_cnt_q, found_cnt_d;
    logic [CNT_W-1:0] stored_q, stored_d;
    logic [15:0]      buf_q [MAX_FOUND];
    logic [15:0]      buf_d [MAX_FOUND];
    logic [15:0]      lo_eff;
    logic             hit;

`ifdef PSCAN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    // Zero is never a candidate, so the sweep starts no lower than 1.
    assign lo_eff = (lo == 16'd0) ? 16'd1 : lo;

    always_comb begin
        state_d     = state_q;
        cur_num_d   = cur_num_q;
        hi_d        = hi_q;
        found_cnt_d = found_cnt_q;
        stored_d    = stored_q;
        buf_d       = buf_q;
        hit         = 1'b0;
`ifdef PSCAN_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    hi_d        = hi;
                    found_cnt_d = 8'd0;
                    stored_d    = '0;
                    for (int i = 0; i < MAX_FOUND; i++) buf_d[i] = 16'd0;
`ifdef PSCAN_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    if (lo_eff > hi) begin
                        state_d = S_DONE;
                    end else begin
                        cur_num_d = lo_eff;
                        state_d   = S_CLR;
                    end
                end
            end
            S_CLR: begin
`ifdef PSCAN_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = S_GO;
            end
            S_GO: state_d = S_WAIT;
            S_WAIT: begin
                if (chk_over) begin
                    hit     = chk_ans;
                    state_d = S_NEXT;
`ifdef PSCAN_TIMEOUT_EN
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    tmo_d   = tmo_q + 1'b1;
`endif
                end
            end
            S_NEXT: begin
                // Compare before increment so hi=65535 ends without wrapping.
                if (cur_num_q == hi_q) begin
                    state_d = S_DONE;
                end else begin
                    cur_num_d = cur_num_q + 16'd1;
                    state_d   = S_CLR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hit) begin
            if (found_cnt_q != 8'hFF) found_cnt_d = found_cnt_q + 8'd1;
            if (stored_q < CNT_W'(MAX_FOUND)) begin
                buf_d[stored_q] = cur_num_q;
                stored_d        = stored_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_num_q   <= 16'd0;
            hi_q        <= 16'd0;
            found_cnt_q <= 8'd0;
            stored_q    <= '0;
            for (int i = 0; i < MAX_FOUND; i++) buf_q[i] <= 16'd0;
        end else begin
            state_q     <= state_d;
            cur_num_q   <= cur_num_d;
            hi_q        <= hi_d;
            found_cnt_q <= found_cnt_d;
            stored_q    <= stored_d;
            buf_q       <= buf_d;
        end
    end

`ifdef PSCAN_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy      = (state_q == S_CLR) || (state_q == S_GO) ||
                       (state_q == S_WAIT) || (state_q == S_NEXT);
    assign done      = (state_q == S_DONE);
    assign chk_rst   = (state_q == S_CLR);
    assign chk_go    = (state_q == S_GO);
    assign cur_num   = cur_num_q;
    assign chk_num   = cur_num_q;
    assign found_cnt = found_cnt_q;
    assign rd_data   = (32'(rd_idx) < 32'(stored_q)) ? buf_q[rd_idx] : 16'd0;

endmodule
